// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload stream from the frame controller to the downstream consumer.
interface uart_rx_frame_ctrl_if;
    logic [7:0] PL_DATA;
    logic       PL_VALID;
    logic       PL_LAST;
    logic       PL_READY;

    modport master (output PL_DATA, output PL_VALID, output PL_LAST, input PL_READY);
    modport slave  (input PL_DATA, input PL_VALID, input PL_LAST, output PL_READY);
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind the UART byte receiver: sync hunt, length-prefixed
// payload capture with additive checksum, then payload release on a stream.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 43400
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ENABLE,
    output logic                        RX_EN,
    input  logic                        RX_DONE,
    input  logic [7:0]                  RX_BYTE,
    uart_rx_frame_ctrl_if.master        pl,
    output logic                        FRAME_OK,
    output logic                        FRAME_ERR,
    output logic [1:0]                  ERR_CODE,
    output logic [7:0]                  DROP_CNT
);

    localparam int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t        state_q;
    logic          rx_en_q;
    logic          rx_done_q;
    logic [7:0]    len_q;
    logic [7:0]    sum_q;
    logic [7:0]    idx_q;
    logic [7:0]    rd_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    pl_data_q;
    logic          pl_valid_q;
    logic          pl_last_q;
    logic          frame_ok_q;
    logic          frame_err_q;
    logic [1:0]    err_code_q;
    logic [7:0]    drop_cnt_q;
    logic [7:0]    buf_q [MAX_LEN];

    logic          rx_evt;
    logic [7:0]    rd_nxt;
    logic [7:0]    len_m1;

    assign rx_evt = RX_DONE & ~rx_done_q;
    assign rd_nxt = rd_q + 8'd1;
    assign len_m1 = len_q - 8'd1;

    assign RX_EN       = rx_en_q;
    assign pl.PL_DATA  = pl_data_q;
    assign pl.PL_VALID = pl_valid_q;
    assign pl.PL_LAST  = pl_last_q;
    assign FRAME_OK    = frame_ok_q;
    assign FRAME_ERR   = frame_err_q;
    assign ERR_CODE    = err_code_q;
    assign DROP_CNT    = drop_cnt_q;

    // Payload buffer write; contents need no reset since idx/len gate every read.
    always_ff @(posedge CLK) begin
        if (state_q == ST_PAYLOAD && rx_evt && ENABLE && !RST) begin
            buf_q[idx_q[AW-1:0]] <= RX_BYTE;
        end
    end

    // Frame sequencer with registered status and stream outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_DISABLED;
            rx_en_q     <= 1'b0;
            rx_done_q   <= 1'b0;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            rd_q        <= '0;
            tmo_q       <= '0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            rx_en_q     <= ENABLE;
            rx_done_q   <= RX_DONE;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (!ENABLE) begin
                state_q    <= ST_DISABLED;
                pl_valid_q <= 1'b0;
                pl_last_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_DISABLED: state_q <= ST_HUNT;
                    ST_HUNT: begin
                        if (rx_evt && RX_BYTE == SYNC_BYTE) begin
                            state_q <= ST_LEN;
                            tmo_q   <= '0;
                        end
                    end
                    ST_LEN, ST_PAYLOAD, ST_CSUM: begin
                        // A byte arriving on the expiry cycle takes priority over the timeout.
                        if (!rx_evt) begin
                            if (tmo_q == TMO_LAST) begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'b11;
                                state_q     <= ST_HUNT;
                            end else begin
                                tmo_q <= tmo_q + 1'b1;
                            end
                        end else begin
                            tmo_q <= '0;
                            if (state_q == ST_LEN) begin
                                len_q <= RX_BYTE;
                                sum_q <= RX_BYTE;
                                if (RX_BYTE == 8'd0 || RX_BYTE > MAX_LEN_B) begin
                                    frame_err_q <= 1'b1;
                                    err_code_q  <= 2'b01;
                                    state_q     <= ST_HUNT;
                                end else begin
                                    idx_q   <= '0;
                                    state_q <= ST_PAYLOAD;
                                end
                            end else if (state_q == ST_PAYLOAD) begin
                                sum_q <= sum_q + RX_BYTE;
                                idx_q <= idx_q + 8'd1;
                                if (idx_q + 8'd1 == len_q) begin
                                    state_q <= ST_CSUM;
                                end
                            end else begin
                                if (RX_BYTE == sum_q) begin
                                    frame_ok_q <= 1'b1;
                                    rd_q       <= '0;
                                    state_q    <= ST_DRAIN;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    err_code_q  <= 2'b10;
                                    state_q     <= ST_HUNT;
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (rx_evt && drop_cnt_q != 8'hFF) begin
                            drop_cnt_q <= drop_cnt_q + 8'd1;
                        end
                        // PL_VALID low inside DRAIN only happens on the first cycle after entry.
                        if (!pl_valid_q) begin
                            pl_valid_q <= 1'b1;
                            pl_data_q  <= buf_q[rd_q[AW-1:0]];
                            pl_last_q  <= (rd_q == len_m1);
                        end else if (pl.PL_READY) begin
                            if (pl_last_q) begin
                                pl_valid_q <= 1'b0;
                                pl_last_q  <= 1'b0;
                                state_q    <= ST_HUNT;
                            end else begin
                                rd_q      <= rd_nxt;
                                pl_data_q <= buf_q[rd_nxt[AW-1:0]];
                                pl_last_q <= (rd_nxt == len_m1);
                            end
                        end
                    end
                    default: state_q <= ST_DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected pulses and
// beats, a negedge monitor pops and compares whatever the DUT presents.
module tb_uart_rx_frame_ctrl;

    localparam int T = 200;
    localparam int K_OK   = 0;
    localparam int K_ERR  = 1;
    localparam int K_BEAT = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ENABLE;
    logic       RX_EN;
    logic       RX_DONE;
    logic [7:0] RX_BYTE;
    logic       FRAME_OK;
    logic       FRAME_ERR;
    logic [1:0] ERR_CODE;
    logic [7:0] DROP_CNT;

    uart_rx_frame_ctrl_if pl_if();

    uart_rx_frame_ctrl #(
        .SYNC_BYTE  (8'hA5),
        .MAX_LEN    (16),
        .TIMEOUT_CYC(T)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ENABLE   (ENABLE),
        .RX_EN    (RX_EN),
        .RX_DONE  (RX_DONE),
        .RX_BYTE  (RX_BYTE),
        .pl       (pl_if),
        .FRAME_OK (FRAME_OK),
        .FRAME_ERR(FRAME_ERR),
        .ERR_CODE (ERR_CODE),
        .DROP_CNT (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       last;
        logic [1:0] code;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   evt_cyc = 0;
    logic prev_pulse = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == K_ERR && e.kind == K_ERR) chk("err_code", {30'd0, ERR_CODE}, {30'd0, e.code});
            if (kind == K_BEAT && e.kind == K_BEAT) begin
                chk("pl_data", {24'd0, pl_if.PL_DATA}, {24'd0, e.data});
                chk("pl_last", {31'd0, pl_if.PL_LAST}, {31'd0, e.last});
            end
        end
    endtask

    // Monitor: every pulse or accepted beat must match the head of the queue.
    always @(negedge CLK) begin
        if (RST) begin
            prev_pulse <= 1'b0;
        end else begin
            if (FRAME_OK || FRAME_ERR) begin
                chk("pulse_exclusive", {31'd0, FRAME_OK & FRAME_ERR}, 32'd0);
                chk("pulse_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
            end
            if (FRAME_OK)  pop_check(K_OK);
            if (FRAME_ERR) pop_check(K_ERR);
            if (pl_if.PL_VALID && pl_if.PL_READY) pop_check(K_BEAT);
            prev_pulse <= FRAME_OK | FRAME_ERR;
        end
    end

    task automatic exp_ok();
        q.push_back('{kind: K_OK, data: 8'd0, last: 1'b0, code: 2'd0});
    endtask

    task automatic exp_err(input logic [1:0] code);
        q.push_back('{kind: K_ERR, data: 8'd0, last: 1'b0, code: code});
    endtask

    task automatic exp_beat(input logic [7:0] d, input logic l);
        q.push_back('{kind: K_BEAT, data: d, last: l, code: 2'd0});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_BYTE = b;
        RX_DONE = 1'b1;
        @(negedge CLK);
        RX_DONE = 1'b0;
        evt_cyc = cyc;
    endtask

    task automatic wait_idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) break;
            @(negedge CLK);
        end
        @(negedge CLK);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        RST = 1'b1; ENABLE = 1'b0; RX_DONE = 1'b0; RX_BYTE = 8'h00;
        pl_if.PL_READY = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_rx_en", {31'd0, RX_EN}, 32'd0);
        chk("rst_pl_valid", {31'd0, pl_if.PL_VALID}, 32'd0);
        chk("rst_err_code", {30'd0, ERR_CODE}, 32'd0);
        chk("rst_drop_cnt", {24'd0, DROP_CNT}, 32'd0);
        chk("rst_pulses", {30'd0, FRAME_OK, FRAME_ERR}, 32'd0);

        RST = 1'b0; ENABLE = 1'b1; pl_if.PL_READY = 1'b1;
        @(negedge CLK);
        chk("rx_en_follows", {31'd0, RX_EN}, 32'd1);
        repeat (2) @(negedge CLK);

        // Basic 3-byte frame
        exp_ok(); exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        wait_idle(20);
        chk("rx_en_steady", {31'd0, RX_EN}, 32'd1);

        // Checksum mismatch, then single-byte frame
        exp_err(2'b10);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h00);
        wait_idle(20);
        chk("err_code_csum", {30'd0, ERR_CODE}, 32'd2);
        exp_ok(); exp_beat(8'h7F, 1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        wait_idle(20);

        // Bad lengths: zero and MAX_LEN+1
        exp_err(2'b01);
        send_byte(8'hA5); send_byte(8'h00);
        wait_idle(20);
        chk("err_code_len0", {30'd0, ERR_CODE}, 32'd1);
        exp_err(2'b01);
        send_byte(8'hA5); send_byte(8'h11);
        wait_idle(20);
        chk("err_code_len17", {30'd0, ERR_CODE}, 32'd1);
        exp_ok(); exp_beat(8'h3C, 1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h3D);
        wait_idle(20);

        // Inter-byte timeout
        exp_err(2'b11);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        t0 = evt_cyc;
        for (int i = 0; i < T + 20; i++) begin
            if (FRAME_ERR) break;
            @(negedge CLK);
        end
        chk("timeout_latency", cyc - t0, T);
        wait_idle(5);
        chk("err_code_tmo", {30'd0, ERR_CODE}, 32'd3);
        exp_ok(); exp_beat(8'h10, 0); exp_beat(8'h20, 1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
        wait_idle(20);

        // Back-pressure with dropped bytes during DRAIN
        pl_if.PL_READY = 1'b0;
        exp_ok(); exp_beat(8'h01, 0); exp_beat(8'h02, 0); exp_beat(8'h03, 0); exp_beat(8'h04, 1);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h0E);
        repeat (3) @(negedge CLK);
        chk("stall_valid", {31'd0, pl_if.PL_VALID}, 32'd1);
        chk("stall_data0", {24'd0, pl_if.PL_DATA}, 32'h01);
        chk("stall_last0", {31'd0, pl_if.PL_LAST}, 32'd0);
        send_byte(8'h55); send_byte(8'hA5); send_byte(8'h00);
        repeat (90) @(negedge CLK);
        chk("stall_data_hold", {24'd0, pl_if.PL_DATA}, 32'h01);
        chk("drop_cnt", {24'd0, DROP_CNT}, 32'd3);
        pl_if.PL_READY = 1'b1;
        wait_idle(20);
        @(negedge CLK);
        chk("valid_drops_after_last", {31'd0, pl_if.PL_VALID}, 32'd0);

        // ENABLE dropped mid-payload: no error, receiver disabled next cycle
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        @(negedge CLK);
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("rx_en_off", {31'd0, RX_EN}, 32'd0);
        repeat (5) @(negedge CLK);
        ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        exp_ok(); exp_beat(8'hAA, 0); exp_beat(8'h55, 1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01);
        wait_idle(20);
        chk("drop_cnt_retained", {24'd0, DROP_CNT}, 32'd3);

        // Reset during DRAIN
        pl_if.PL_READY = 1'b0;
        exp_ok();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        repeat (3) @(negedge CLK);
        chk("drain_valid", {31'd0, pl_if.PL_VALID}, 32'd1);
        send_byte(8'h42);
        chk("drop_cnt_4", {24'd0, DROP_CNT}, 32'd4);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_drain_valid", {31'd0, pl_if.PL_VALID}, 32'd0);
        chk("rst_drain_drop", {24'd0, DROP_CNT}, 32'd0);
        chk("rst_drain_rx_en", {31'd0, RX_EN}, 32'd0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        wait_idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Sequencer placed directly after the UART_RX byte receiver.
- Drives the receiver's enable.
- Hunts for a sync byte, then collects a length-prefixed payload and a checksum into an internal buffer.
- On a valid checksum, releases the payload downstream through a valid/ready stream. Otherwise reports a coded error.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload length in bytes (1..255); also the buffer depth.
- TIMEOUT_CYC, 43400, inter-byte timeout in CLK cycles (10 byte times at 115200 baud, 50 MHz).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  controller enable; low forces the DISABLED state.
- RX_EN  out  1  enable to the UART receiver.
- RX_DONE  in  1  byte-complete strobe from the receiver (level; rising edge used).
- RX_BYTE  in  8  received byte; valid when RX_DONE rises.
- PL_DATA  out  8  payload byte.
- PL_VALID  out  1  PL_DATA valid.
- PL_LAST  out  1  final payload byte of the frame, qualified by PL_VALID.
- PL_READY  in  1  downstream accepts the beat when PL_VALID & PL_READY.
- FRAME_OK  out  1  one-cycle pulse when a frame passes checksum.
- FRAME_ERR  out  1  one-cycle pulse on a frame error.
- ERR_CODE  out  2  01 = bad length, 10 = checksum mismatch, 11 = timeout; holds its last value.
- DROP_CNT  out  8  saturating count of bytes dropped while in DRAIN.

Behaviour:
- Reset: state DISABLED; all outputs 0; ERR_CODE=00; DROP_CNT=0; checksum, index and timeout counters cleared.
- RX_EN is registered: it equals ENABLE one cycle later, is 0 during RST, and is never deasserted by the FSM itself.
- Byte event: rx_evt = RX_DONE & ~RX_DONE_q (one-cycle edge detect). RX_BYTE is sampled on that cycle.
- DISABLED: wait for ENABLE=1, then go to HUNT.
- HUNT: on rx_evt with byte == SYNC_BYTE, go to LEN; other bytes are ignored silently.
- LEN: on rx_evt, store len=byte and set sum=byte.
  - If len==0 or len>MAX_LEN: pulse FRAME_ERR, set ERR_CODE=01, go to HUNT.
  - Otherwise set idx=0 and go to PAYLOAD.
- PAYLOAD: on rx_evt, write buf[idx]=byte, sum=sum+byte (mod 256), idx=idx+1. When idx reaches len, go to CSUM.
- CSUM: on rx_evt, compare byte with sum.
  - Equal: pulse FRAME_OK and go to DRAIN.
  - Not equal: pulse FRAME_ERR, set ERR_CODE=10, go to HUNT.
- Timeout (LEN, PAYLOAD, CSUM only): counter clears on entry and on every rx_evt, and increments otherwise.
  - When it reaches TIMEOUT_CYC-1: pulse FRAME_ERR, set ERR_CODE=11, go to HUNT.
  - rx_evt on that same cycle wins; no timeout is reported.
- DRAIN:
  - Read index starts at 0. PL_VALID rises the cycle after entry; PL_DATA=buf[rd]; PL_LAST=(rd==len-1).
  - PL_DATA, PL_LAST and PL_VALID stay stable until accepted.
  - On accept, rd increments and the next byte appears on the following cycle; back-to-back beats at 1/cycle are allowed.
  - Accepting the last beat drops PL_VALID the next cycle and returns to HUNT.
  - Any rx_evt in DRAIN increments DROP_CNT (saturates at 255), and the byte is discarded.
- ENABLE low in any state: next state is DISABLED; PL_VALID drops next cycle; buffer and partial frame are discarded; no FRAME_ERR pulse; DROP_CNT is retained.
- RST mid-frame or mid-drain: full reset as above on the next edge.
- FRAME_OK and FRAME_ERR are mutually exclusive and never high for two consecutive cycles.

Test Plan:
- Reset, ENABLE=1, send A5 03 11 22 33 69, PL_READY=1 -> FRAME_OK pulse; PL_DATA 11,22,33 on consecutive accepted beats; PL_LAST on 33; RX_EN=1 throughout.
- Send A5 03 11 22 33 00 -> FRAME_ERR pulse, ERR_CODE=10, PL_VALID never asserts; then a valid frame A5 01 7F 80 -> FRAME_OK, single beat 7F with PL_LAST.
- Send A5 00 and separately A5 11 (17>MAX_LEN) -> FRAME_ERR each time, ERR_CODE=01, state back to HUNT (next A5 accepted).
- Send A5 02 10, then idle for TIMEOUT_CYC cycles -> FRAME_ERR, ERR_CODE=11 exactly TIMEOUT_CYC cycles after the last rx_evt; a following valid frame is received correctly.
- Valid 4-byte frame with PL_READY=0 for 100 cycles; send 3 bytes meanwhile -> PL_DATA holds byte 0 stable, DROP_CNT=3; raise PL_READY -> 4 beats, PL_LAST on the 4th.
- Drop ENABLE mid-PAYLOAD, then re-enable and send a valid frame -> no FRAME_ERR, RX_EN low one cycle after ENABLE fell; the new frame yields FRAME_OK with correct data. Assert RST during DRAIN -> PL_VALID=0 and DROP_CNT=0 next cycle.
